instruction_encoder_loader: RTL and testbench

//  Inverse of the CPU instruction decoder: packs MIPS field tuples (R/I/J) into 32-bit words
//  and writes them sequentially into instruction memory through its write port.

---
 rtl/instruction_encoder_loader_if.sv | 42 ++++
 rtl/instruction_encoder_loader.sv | 124 ++++++++++++
 tb/tb_instruction_encoder_loader.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_encoder_loader_if.sv
// Bundle of the field-level source handshake, the instruction memory write
// port and the load status outputs of instruction_encoder_loader.
//   slave  : the loader itself (consumes tuples, drives memory + status)
//   master : the program source / test driver
interface instruction_encoder_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    // control / source side
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            fmt;
    logic [5:0]            OP;
    logic [4:0]            RS;
    logic [4:0]            RT;
    logic [4:0]            RD;
    logic [4:0]            SHAMT;
    logic [5:0]            FUNCT;
    logic [15:0]           IMM16;
    logic [25:0]           TA;
    logic [31:0]           raw;
    logic                  last;
    // instruction memory write port
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    // status
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [ADDR_WIDTH:0]   count;

    modport slave (
        input  start, in_valid, fmt, OP, RS, RT, RD, SHAMT, FUNCT, IMM16, TA, raw, last,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow, count
    );

    modport master (
        output start, in_valid, fmt, OP, RS, RT, RD, SHAMT, FUNCT, IMM16, TA, raw, last,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow, count
    );
endinterface

// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader
//   Packs MIPS R/I/J field tuples (or a raw word) into 32-bit instructions and
//   writes them to consecutive instruction-memory words starting at BASE_ADDR.
// Ports:
//   clk      : clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : instruction_encoder_loader_if.slave
//              start/in_valid/in_ready + fields in; mem_we/mem_addr/mem_wdata
//              out; busy/done/overflow/count status out.
module instruction_encoder_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    instruction_encoder_loader_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  full_q, full_d;      // top word already written
    logic [31:0]           wdata_q, wdata_d;
    logic                  last_q, last_d;      // word in flight ends the program
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic [31:0]           enc_word;
    logic                  accept;

    always_comb begin
        enc_word = bus.raw;
        unique case (bus.fmt)
            2'b00:   enc_word = {bus.OP, bus.RS, bus.RT, bus.RD, bus.SHAMT, bus.FUNCT};
            2'b01:   enc_word = {bus.OP, bus.RS, bus.RT, bus.IMM16};
            2'b10:   enc_word = {bus.OP, bus.TA};
            default: enc_word = bus.raw;
        endcase
    end

    assign accept = (state_q == S_LOAD) && !full_q && bus.in_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            full_q  <= 1'b0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            full_q  <= full_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        full_d  = full_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // a tuple offered together with start is left waiting for LOAD
                if (bus.start) begin
                    state_d = S_LOAD;
                    addr_d  = BASE;
                    full_d  = 1'b0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    state_d = S_WRITE;
                    wdata_d = enc_word;
                    last_d  = bus.last;
                end else if (full_q && bus.in_valid) begin
                    // memory exhausted: refuse the tuple and end the load
                    state_d = S_DONE;
                    ovf_d   = 1'b1;
                end
            end
            S_WRITE: begin
                count_d = count_q + 1'b1;
                // no wrap: the top word marks the memory full instead
                if (addr_q == LAST_ADDR) full_d = 1'b1;
                else                     addr_d = addr_q + 1'b1;
                state_d = last_q ? S_DONE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // mem_we decodes straight from the state register so reset kills it at once
    assign bus.in_ready  = (state_q == S_LOAD) && !full_q;
    assign bus.mem_we    = (state_q == S_WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.overflow  = ovf_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Testbench for instruction_encoder_loader (ADDR_WIDTH=2 so memory-full
// boundaries are reached often). A session-level model predicts every
// output each cycle; directed sequences pin known encodings and boundaries.
module tb_instruction_encoder_loader;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int BASE  = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_encoder_loader_if #(.ADDR_WIDTH(AW)) bus ();

    instruction_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] ta;
        logic [31:0] raw;
        logic        last;
    } tup_t;

    // model of one load session
    typedef struct {
        bit          active;   // load session open
        bit          done;
        bit          wr;       // a word is being written this cycle
        bit          end_after;
        bit          ovf;
        int          next;     // next word address; DEPTH means memory full
        int          cnt;
        logic [31:0] wdata;
    } m_t;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    m_t m;
    logic [31:0] img [DEPTH];
    int wr_cnt = 0;
    int last_waddr = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] enc(input logic [1:0] f, input logic [5:0] op,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn, input logic [15:0] imm,
                                        input logic [25:0] ta, input logic [31:0] raw);
        logic [31:0] w;
        case (f)
            2'd0: w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) |
                      (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
            2'd1: w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            2'd2: w = (32'(op) << 26) | 32'(ta);
            default: w = raw;
        endcase
        return w;
    endfunction

    function automatic m_t m_reset();
        m_t r;
        r.active = 0; r.done = 0; r.wr = 0; r.end_after = 0; r.ovf = 0;
        r.next = BASE; r.cnt = 0; r.wdata = '0;
        return r;
    endfunction

    function automatic m_t step(input m_t c, input bit st, input bit v, input bit l,
                                input logic [31:0] w);
        m_t n = c;
        if (c.wr) begin
            n.wr   = 0;
            n.cnt  = c.cnt + 1;
            n.next = c.next + 1;
            if (c.end_after) begin n.active = 0; n.done = 1; end
        end else if (c.active) begin
            if (v) begin
                if (c.next < DEPTH) begin
                    n.wr = 1; n.wdata = w; n.end_after = l;
                end else begin
                    n.ovf = 1; n.active = 0; n.done = 1;
                end
            end
        end else if (st) begin
            n.active = 1; n.done = 0; n.cnt = 0; n.ovf = 0; n.next = BASE;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else m <= step(m, bus.start, bus.in_valid, bus.last,
                       enc(bus.fmt, bus.OP, bus.RS, bus.RT, bus.RD, bus.SHAMT,
                           bus.FUNCT, bus.IMM16, bus.TA, bus.raw));
    end

    always @(posedge clk) cyc <= cyc + 1;

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready",  32'(bus.in_ready), 32'(m.active && !m.wr && m.next < DEPTH));
            chk("mem_we",    32'(bus.mem_we),   32'(m.wr));
            chk("mem_addr",  32'(bus.mem_addr), 32'((m.next >= DEPTH) ? DEPTH - 1 : m.next));
            chk("mem_wdata", bus.mem_wdata,     m.wdata);
            chk("busy",      32'(bus.busy),     32'(m.active));
            chk("done",      32'(bus.done),     32'(m.done));
            chk("overflow",  32'(bus.overflow), 32'(m.ovf));
            chk("count",     32'(bus.count),    32'(m.cnt));
        end
    end

    // memory image captured from the write port
    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            img[bus.mem_addr] <= bus.mem_wdata;
            last_waddr        <= int'(bus.mem_addr);
            wr_cnt            <= wr_cnt + 1;
        end
    end

    task automatic put(input tup_t t);
        bus.fmt = t.fmt; bus.OP = t.op; bus.RS = t.rs; bus.RT = t.rt; bus.RD = t.rd;
        bus.SHAMT = t.sh; bus.FUNCT = t.fn; bus.IMM16 = t.imm; bus.TA = t.ta;
        bus.raw = t.raw; bus.last = t.last;
    endtask

    function automatic tup_t rand_tup(input bit l);
        tup_t t;
        t.fmt = 2'($urandom_range(0, 3)); t.op = 6'($urandom); t.rs = 5'($urandom);
        t.rt = 5'($urandom); t.rd = 5'($urandom); t.sh = 5'($urandom);
        t.fn = 6'($urandom); t.imm = 16'($urandom); t.ta = 26'($urandom);
        t.raw = $urandom; t.last = l;
        return t;
    endfunction

    function automatic tup_t mk(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
                                input logic [15:0] imm, input logic [25:0] ta, input bit l);
        tup_t t = rand_tup(l);   // unused fields random: they must be ignored
        t.fmt = f; t.op = op; t.last = l;
        if (f != 2'd2) begin t.rs = rs; t.rt = rt; end
        if (f == 2'd0) begin t.rd = rd; t.sh = 5'd0; t.fn = fn; end
        if (f == 2'd1) t.imm = imm;
        if (f == 2'd2) t.ta = ta;
        return t;
    endfunction

    function automatic logic [31:0] enc_t(input tup_t t);
        return enc(t.fmt, t.op, t.rs, t.rt, t.rd, t.sh, t.fn, t.imm, t.ta, t.raw);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    // offer a tuple until accepted (bounded); valid stays high unless drop
    task automatic send(input tup_t t, input bit drop, input int maxw, output bit acc);
        bit rdy;
        put(t);
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < maxw && !acc; i++) begin
            @(negedge clk); rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) acc = 1'b1;
        end
        if (drop) bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.done) ok = 1'b1;
        end
        chk(nm, 32'(ok), 32'd1);
        tick(1);
    endtask

    initial begin
        bit acc;
        tup_t t, tq [4];
        int c0, w0;

        bus.start = 0; bus.in_valid = 0;
        put(rand_tup(0));
        tick(2);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_addr",   32'(bus.mem_addr), 32'(BASE));
        chk("rst_wdata",  bus.mem_wdata, 0);
        chk("rst_count",  32'(bus.count), 0);
        chk("rst_ready",  32'(bus.in_ready), 0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        tick(2);

        // R: add $3,$1,$2
        do_start();
        send(mk(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1), 1, 8, acc);
        chk("t1_accept", 32'(acc), 1);
        wait_done("t1_done");
        chk("t1_word0", img[0], 32'h00221820);
        chk("t1_count", 32'(bus.count), 1);

        // I addi $8,$0,5 then J 0x0100000 (last)
        do_start();
        send(mk(2'd1, 6'd8, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 0), 1, 8, acc);
        chk("t2_accept_i", 32'(acc), 1);
        send(mk(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0100000, 1), 1, 8, acc);
        chk("t2_accept_j", 32'(acc), 1);
        wait_done("t2_done");
        chk("t2_word0", img[0], 32'h20080005);
        chk("t2_word1", img[1], 32'h08100000);
        chk("t2_count", 32'(bus.count), 2);

        // valid held high for four tuples; the fourth fills memory and is last
        do_start();
        w0 = wr_cnt;
        c0 = 0;
        for (int k = 0; k < 4; k++) begin
            tq[k] = rand_tup(k == 3);
            send(tq[k], 0, 8, acc);
            chk("t3_accept", 32'(acc), 1);
            if (k == 0) c0 = cyc;
        end
        chk("t3_accept_spacing", 32'(cyc - c0), 32'd6);
        bus.in_valid = 1'b0;
        wait_done("t3_done");
        chk("t3_writes", 32'(wr_cnt - w0), 4);
        for (int k = 0; k < 4; k++) chk("t3_word", img[k], enc_t(tq[k]));
        chk("t3_overflow", 32'(bus.overflow), 0);
        chk("t3_count", 32'(bus.count), 4);

        // five tuples without last: the fifth is refused
        do_start();
        for (int k = 0; k < 4; k++) begin
            send(rand_tup(0), 0, 8, acc);
            chk("t4_accept", 32'(acc), 1);
        end
        send(rand_tup(0), 1, 4, acc);
        chk("t4_fifth_refused", 32'(acc), 0);
        chk("t4_overflow", 32'(bus.overflow), 1);
        chk("t4_done", 32'(bus.done), 1);
        chk("t4_count", 32'(bus.count), 4);

        // restart from DONE with a tuple offered in the same cycle
        t = rand_tup(1);
        put(t);
        bus.in_valid = 1'b1;
        do_start();
        chk("t5_overflow_clr", 32'(bus.overflow), 0);
        chk("t5_count_clr", 32'(bus.count), 0);
        chk("t5_ready", 32'(bus.in_ready), 1);
        send(t, 1, 8, acc);
        chk("t5_accept", 32'(acc), 1);
        wait_done("t5_done");
        chk("t5_addr", 32'(last_waddr), 32'(BASE));
        chk("t5_word", img[BASE], enc_t(t));

        // asynchronous reset in the middle of a write
        do_start();
        send(rand_tup(0), 1, 8, acc);
        chk("t6_in_write", 32'(bus.mem_we), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_mem_we",  32'(bus.mem_we), 0);
        chk("t6_busy",    32'(bus.busy), 0);
        chk("t6_done",    32'(bus.done), 0);
        chk("t6_ready",   32'(bus.in_ready), 0);
        chk("t6_ovf",     32'(bus.overflow), 0);
        chk("t6_addr",    32'(bus.mem_addr), 32'(BASE));
        chk("t6_wdata",   bus.mem_wdata, 0);
        chk("t6_count",   32'(bus.count), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        tick(1);

        // randomized traffic, model checks every cycle
        for (int i = 0; i < 800; i++) begin
            bus.start    = ($urandom_range(0, 11) == 0);
            bus.in_valid = ($urandom_range(0, 2) != 0);
            put(rand_tup($urandom_range(0, 5) == 0));
            tick(1);
        end
        bus.start = 0; bus.in_valid = 0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
